gcd_client: RTL and testbench
=============================

GCD_CLIENT -- requirements
Module: gcd_client

Interface
REQ-001 Parameter: W, 32, operand/result width in bits.
REQ-002 Parameter: DEPTH, 4, max in-flight GCD requests at the coprocessor; power of 2, >=2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-005 req_val  input  1  host has an operand pair.
REQ-006 req_rdy  output  1  block accepts the host pair this cycle.
REQ-007 req_A, req_B  input  W each  host operands.
REQ-008 operands_val  output  1  operand pair valid toward coprocessor.
REQ-009 operands_rdy  input  1  coprocessor accepts the pair.
REQ-010 operands_bits_A, operands_bits_B  output  W each  operands to coprocessor.
REQ-011 result_val  input  1  coprocessor result valid.
REQ-012 result_rdy  output  1  block accepts the result.
REQ-013 result_bits  input  W  GCD result.
REQ-014 resp_val  output  1  result valid toward host.
REQ-015 resp_rdy  input  1  host accepts the result.
REQ-016 resp_bits  output  W  GCD result to host.
REQ-017 resp_tag  output  8  result sequence number.
REQ-018 out_cnt  output  clog2(DEPTH)+1  current in-flight count.
REQ-019 proto_err  output  1  sticky protocol-error flag.

Function
REQ-020 A transfer SHALL occur on any val/rdy pair only in a cycle where both are high at the rising edge.
REQ-021 Operand register SHALL have two states: EMPTY and FULL; host accept moves EMPTY->FULL, capturing req_A/req_B; issue with no same-cycle host accept moves FULL->EMPTY; issue plus host accept stays FULL with new data.
REQ-022 operands_val SHALL equal (state==FULL) AND (out_cnt < DEPTH); operands_bits_* SHALL be driven from the operand register only.
REQ-023 req_rdy SHALL equal (state==EMPTY) OR (operands_val AND operands_rdy), with no combinational path from req_val.
REQ-024 Latency: a pair accepted from the host at edge N SHALL be presented on operands_val no earlier than the cycle after edge N.
REQ-025 operands_val, once high, SHALL stay high with stable operands until issued, except when reset asserts.
REQ-026 out_cnt SHALL increment on issue only, decrement on result accept only, and hold when both occur in the same cycle.
REQ-027 Response register SHALL be one entry; result_rdy SHALL equal (NOT resp_val) OR resp_rdy.
REQ-028 On result accept, resp_bits SHALL capture result_bits, resp_tag SHALL take the sequence counter, the counter SHALL increment, and resp_val SHALL be high the next cycle.
REQ-029 The sequence counter SHALL be 8 bits and wrap 255->0.
REQ-030 resp_val SHALL clear after a host accept unless a new result is accepted in the same cycle; resp_bits/resp_tag SHALL hold while resp_val is high and resp_rdy is low.
REQ-031 A result accepted while out_cnt==0 SHALL set proto_err, leave out_cnt at 0 (no underflow), and still be delivered to the host.
REQ-032 proto_err SHALL clear only on reset.
REQ-033 Results SHALL reach the host in coprocessor return order; no reordering or dropping is permitted.

Reset
REQ-034 While reset is low, the block SHALL hold operand state EMPTY and out_cnt=0, and drive operands_val=0, resp_val=0, req_rdy=1, result_rdy=1, proto_err=0, resp_tag=0, with all data outputs at 0.
REQ-035 Reset asserted mid-operation SHALL discard held operands and responses and restart the sequence counter at 0 on the next transaction.

Verification
REQ-036 Single request: host A=27,B=15; responder returns 3 -> operands seen once, resp_bits=3, resp_tag=0, out_cnt goes 0->1->0.
REQ-037 Outstanding limit (DEPTH=4): result_val held 0, 6 host requests -> exactly 4 issues, out_cnt=4, operands_val=0, req_rdy=0 after the 5th pair is registered.
REQ-038 Host backpressure: resp_rdy=0 with 2 results returned (12, then 5) -> result_rdy drops after the first; after resp_rdy=1 the host sees 12 (tag 0), then 5 (tag 1).
REQ-039 Same-cycle issue and result accept at out_cnt=2 -> out_cnt stays 2.
REQ-040 Spurious result_val with out_cnt=0, result=7 -> proto_err=1 and sticky, out_cnt=0, resp_bits=7 delivered.
REQ-041 Wrap and reset: 257 results -> the last one has resp_tag=0; then reset low with out_cnt=2 and the operand register FULL -> all outputs at REQ-034 values in the same cycle.

Source files
------------

// File: rtl/gcd_client.sv
// rtl/gcd_client.sv - host-side client that feeds a GCD coprocessor and returns tagged results
//
// Purpose:
//   Accepts operand pairs from a host and holds them in a one-entry operand register.
//   Issues those pairs to a GCD coprocessor, with at most DEPTH requests in flight.
//   Collects results into a one-entry response register.
//   Tags each result with an 8-bit sequence number and returns it to the host in the
//   order the coprocessor produced it.
//
// Ports:
//   clk, reset (async, active-low)
//   host request      : req_val / req_rdy / req_A / req_B
//   coprocessor issue : operands_val / operands_rdy / operands_bits_A / operands_bits_B
//   coprocessor result: result_val / result_rdy / result_bits
//   host response     : resp_val / resp_rdy / resp_bits / resp_tag
//   status            : out_cnt (requests in flight), proto_err (sticky)
module gcd_client #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic [W-1:0]             req_A,
  input  logic [W-1:0]             req_B,
  output logic                     operands_val,
  input  logic                     operands_rdy,
  output logic [W-1:0]             operands_bits_A,
  output logic [W-1:0]             operands_bits_B,
  input  logic                     result_val,
  output logic                     result_rdy,
  input  logic [W-1:0]             result_bits,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic [W-1:0]             resp_bits,
  output logic [7:0]               resp_tag,
  output logic [$clog2(DEPTH):0]   out_cnt,
  output logic                     proto_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } op_state_t;

  op_state_t     op_state;
  logic [W-1:0]  op_a_q;
  logic [W-1:0]  op_b_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    seq_q;
  logic          resp_val_q;
  logic [W-1:0]  resp_bits_q;
  logic [7:0]    resp_tag_q;
  logic          proto_err_q;

  logic issue;
  logic host_acc;
  logic res_acc;

  // Issue is throttled by the in-flight count.
  // The operand register keeps its pair while the count is at DEPTH.
  assign operands_val    = (op_state == FULL) && (cnt_q < DEPTH_C);
  assign operands_bits_A = op_a_q;
  assign operands_bits_B = op_b_q;
  assign issue           = operands_val && operands_rdy;

  // req_rdy depends only on state and the coprocessor side.
  // It never depends on req_val.
  assign req_rdy  = (op_state == EMPTY) || issue;
  assign host_acc = req_val && req_rdy;

  // The response register can take a new result when it is empty.
  // It can also take one in the same cycle the host drains it.
  assign result_rdy = !resp_val_q || resp_rdy;
  assign res_acc    = result_val && result_rdy;

  assign resp_val  = resp_val_q;
  assign resp_bits = resp_bits_q;
  assign resp_tag  = resp_tag_q;
  assign out_cnt   = cnt_q;
  assign proto_err = proto_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_state    <= EMPTY;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cnt_q       <= '0;
      seq_q       <= '0;
      resp_val_q  <= 1'b0;
      resp_bits_q <= '0;
      resp_tag_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      // Operand register.
      // In FULL, a host accept implies a same-cycle issue, so the register refills.
      case (op_state)
        EMPTY: begin
          if (host_acc) begin
            op_state <= FULL;
            op_a_q   <= req_A;
            op_b_q   <= req_B;
          end
        end
        FULL: begin
          if (host_acc) begin
            op_a_q <= req_A;
            op_b_q <= req_B;
          end else if (issue) begin
            op_state <= EMPTY;
          end
        end
        default: op_state <= EMPTY;
      endcase

      // In-flight count.
      // It holds when an issue and a result accept land in the same cycle.
      // A result with nothing in flight never drives it below zero.
      if (issue && !res_acc) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (res_acc && !issue && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CW'(1);
      end

      if (res_acc && (cnt_q == '0)) begin
        proto_err_q <= 1'b1;
      end

      // Response register.
      // Data and tag change only when a new result is captured.
      if (res_acc) begin
        resp_val_q  <= 1'b1;
        resp_bits_q <= result_bits;
        resp_tag_q  <= seq_q;
        seq_q       <= seq_q + 8'd1;
      end else if (resp_val_q && resp_rdy) begin
        resp_val_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gcd_client.sv
// tb/tb_gcd_client.sv - scoreboard bench for gcd_client
module tb_gcd_client;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_val;
  logic          req_rdy;
  logic [W-1:0]  req_A;
  logic [W-1:0]  req_B;
  logic          operands_val;
  logic          operands_rdy;
  logic [W-1:0]  operands_bits_A;
  logic [W-1:0]  operands_bits_B;
  logic          result_val;
  logic          result_rdy;
  logic [W-1:0]  result_bits;
  logic          resp_val;
  logic          resp_rdy;
  logic [W-1:0]  resp_bits;
  logic [7:0]    resp_tag;
  logic [CW-1:0] out_cnt;
  logic          proto_err;

  gcd_client #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_A(req_A), .req_B(req_B),
    .operands_val(operands_val), .operands_rdy(operands_rdy),
    .operands_bits_A(operands_bits_A), .operands_bits_B(operands_bits_B),
    .result_val(result_val), .result_rdy(result_rdy), .result_bits(result_bits),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_bits(resp_bits), .resp_tag(resp_tag),
    .out_cnt(out_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] bits;
    logic [7:0]   tag;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         model_cnt;
  int         issued;
  int         accepted;
  int         returned;
  logic [7:0] exp_seq;
  logic [7:0] last_tag;

  // Records the handshakes that will fire at the coming rising edge.
  // Returns at the next falling edge.
  task automatic step();
    exp_t e;
    bit   iss;
    bit   racc;
    #1;
    iss  = operands_val && operands_rdy;
    racc = result_val && result_rdy;
    if (iss) issued++;
    if (req_val && req_rdy) accepted++;
    if (resp_val && resp_rdy) begin
      vectors++;
      last_tag = resp_tag;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL resp_unexpected: got bits=%0d tag=%0d, required no response", resp_bits, resp_tag);
      end else begin
        e = sb.pop_front();
        if ({resp_bits, resp_tag} !== {e.bits, e.tag}) begin
          miscompares++;
          $display("FAIL resp_order: got bits=%0d tag=%0d, required bits=%0d tag=%0d",
                   resp_bits, resp_tag, e.bits, e.tag);
        end
      end
    end
    if (racc) begin
      sb.push_back('{bits: result_bits, tag: exp_seq});
      exp_seq = exp_seq + 8'd1;
      returned++;
    end
    if (iss && !racc) model_cnt++;
    else if (racc && !iss && model_cnt > 0) model_cnt--;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_val = 1'b0; req_A = '0; req_B = '0;
    operands_rdy = 1'b0; result_val = 1'b0; result_bits = '0; resp_rdy = 1'b0;
    sb.delete();
    model_cnt = 0; issued = 0; accepted = 0; returned = 0; exp_seq = 8'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Returns every in-flight result and empties the response path.
  task automatic drain(input string name);
    int guard = 0;
    req_val = 1'b0; operands_rdy = 1'b1; resp_rdy = 1'b1;
    while ((model_cnt > 0 || operands_val || sb.size() > 0 || resp_val) && guard < 200) begin
      result_val  = (model_cnt > 0);
      result_bits = $urandom;
      step();
      guard++;
      vectors++;
      if (out_cnt !== CW'(model_cnt)) begin
        miscompares++;
        $display("FAIL %s_cnt: got %0d, required %0d", name, out_cnt, model_cnt);
      end
    end
    result_val = 1'b0; operands_rdy = 1'b0; resp_rdy = 1'b0;
    vectors++;
    if (guard >= 200) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d cycles, required < 200", name, guard);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_val = 1'b1; req_A = 32'd9; req_B = 32'd6;
    operands_rdy = 1'b1; result_val = 1'b0; result_bits = '0; resp_rdy = 1'b0;
    sb.delete(); model_cnt = 0; issued = 0; accepted = 0; returned = 0; exp_seq = 8'd0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({operands_val, resp_val, req_rdy, result_rdy, proto_err, out_cnt, resp_tag,
         resp_bits, operands_bits_A, operands_bits_B} !==
        {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 32'd0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_values: got ov=%b rv=%b qr=%b rr=%b pe=%b cnt=%0d tag=%0d, required 0 0 1 1 0 0 0",
               operands_val, resp_val, req_rdy, result_rdy, proto_err, out_cnt, resp_tag);
    end
    req_val = 1'b0; operands_rdy = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    req_val = 1'b1; req_A = 32'd27; req_B = 32'd15;
    vectors++;
    if (operands_val !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency: got operands_val=%b, required 0", operands_val);
    end
    step();
    req_val = 1'b0;
    vectors++;
    if ({operands_val, operands_bits_A, operands_bits_B, out_cnt} !== {1'b1, 32'd27, 32'd15, 3'd0}) begin
      miscompares++;
      $display("FAIL single_operands: got val=%b A=%0d B=%0d cnt=%0d, required 1 27 15 0",
               operands_val, operands_bits_A, operands_bits_B, out_cnt);
    end
    operands_rdy = 1'b1;
    step();
    operands_rdy = 1'b0;
    vectors++;
    if ({operands_val, out_cnt} !== {1'b0, 3'd1} || issued !== 1) begin
      miscompares++;
      $display("FAIL single_issue: got val=%b cnt=%0d issues=%0d, required 0 1 1", operands_val, out_cnt, issued);
    end
    result_val = 1'b1; result_bits = 32'd3;
    step();
    result_val = 1'b0;
    vectors++;
    if ({out_cnt, resp_val, resp_bits, resp_tag} !== {3'd0, 1'b1, 32'd3, 8'd0}) begin
      miscompares++;
      $display("FAIL single_resp: got cnt=%0d val=%b bits=%0d tag=%0d, required 0 1 3 0",
               out_cnt, resp_val, resp_bits, resp_tag);
    end
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    vectors++;
    if (resp_val !== 1'b0) begin
      miscompares++;
      $display("FAIL single_resp_clear: got resp_val=%b, required 0", resp_val);
    end
  endtask

  task automatic test_outstanding();
    do_reset();
    operands_rdy = 1'b1; req_val = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req_A = 32'd10 + 32'(accepted);
      req_B = 32'd20 + 32'(accepted);
      step();
    end
    req_val = 1'b0;
    vectors++;
    if (issued !== 4 || accepted !== 5) begin
      miscompares++;
      $display("FAIL limit_counts: got issues=%0d accepts=%0d, required 4 5", issued, accepted);
    end
    vectors++;
    if ({out_cnt, operands_val, req_rdy} !== {3'd4, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL limit_state: got cnt=%0d ov=%b req_rdy=%b, required 4 0 0", out_cnt, operands_val, req_rdy);
    end
    vectors++;
    if ({operands_bits_A, operands_bits_B} !== {32'd14, 32'd24}) begin
      miscompares++;
      $display("FAIL limit_hold: got A=%0d B=%0d, required 14 24", operands_bits_A, operands_bits_B);
    end
    drain("limit");
    vectors++;
    if (issued !== 5 || proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL limit_drain: got issues=%0d proto_err=%b, required 5 0", issued, proto_err);
    end
  endtask

  task automatic test_backpressure();
    int g = 0;
    do_reset();
    operands_rdy = 1'b1;
    while (issued < 2 && g < 20) begin
      req_val = (accepted < 2);
      req_A = 32'd4; req_B = 32'd8;
      step();
      g++;
    end
    req_val = 1'b0; operands_rdy = 1'b0;
    result_val = 1'b1; result_bits = 32'd12; resp_rdy = 1'b0;
    step();
    vectors++;
    if ({resp_val, resp_bits, resp_tag, result_rdy, out_cnt} !== {1'b1, 32'd12, 8'd0, 1'b0, 3'd1}) begin
      miscompares++;
      $display("FAIL bp_first: got val=%b bits=%0d tag=%0d result_rdy=%b cnt=%0d, required 1 12 0 0 1",
               resp_val, resp_bits, resp_tag, result_rdy, out_cnt);
    end
    result_bits = 32'd5;
    step();
    vectors++;
    if ({resp_bits, resp_tag, out_cnt} !== {32'd12, 8'd0, 3'd1}) begin
      miscompares++;
      $display("FAIL bp_hold: got bits=%0d tag=%0d cnt=%0d, required 12 0 1", resp_bits, resp_tag, out_cnt);
    end
    resp_rdy = 1'b1;
    step();
    result_val = 1'b0;
    vectors++;
    if ({resp_val, resp_bits, resp_tag} !== {1'b1, 32'd5, 8'd1}) begin
      miscompares++;
      $display("FAIL bp_second: got val=%b bits=%0d tag=%0d, required 1 5 1", resp_val, resp_bits, resp_tag);
    end
    step();
    resp_rdy = 1'b0;
    vectors++;
    if (resp_val !== 1'b0 || out_cnt !== 3'd0 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL bp_done: got val=%b cnt=%0d pending=%0d, required 0 0 0", resp_val, out_cnt, sb.size());
    end
  endtask

  task automatic test_same_cycle();
    int g = 0;
    do_reset();
    while ((issued < 2 || accepted < 3) && g < 20) begin
      req_val = (accepted < 3);
      operands_rdy = (issued < 2);
      req_A = 32'd30 + 32'(accepted); req_B = 32'd6;
      step();
      g++;
    end
    req_val = 1'b0;
    vectors++;
    if ({out_cnt, operands_val} !== {3'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL same_setup: got cnt=%0d ov=%b, required 2 1", out_cnt, operands_val);
    end
    operands_rdy = 1'b1; result_val = 1'b1; result_bits = 32'd9; resp_rdy = 1'b1;
    step();
    result_val = 1'b0; operands_rdy = 1'b0;
    vectors++;
    if (out_cnt !== 3'd2 || issued !== 3) begin
      miscompares++;
      $display("FAIL same_cycle_cnt: got cnt=%0d issues=%0d, required 2 3", out_cnt, issued);
    end
    drain("same");
  endtask

  task automatic test_proto_err();
    do_reset();
    result_val = 1'b1; result_bits = 32'd7; resp_rdy = 1'b0;
    step();
    result_val = 1'b0;
    vectors++;
    if ({proto_err, out_cnt, resp_val, resp_bits} !== {1'b1, 3'd0, 1'b1, 32'd7}) begin
      miscompares++;
      $display("FAIL proto_set: got pe=%b cnt=%0d val=%b bits=%0d, required 1 0 1 7",
               proto_err, out_cnt, resp_val, resp_bits);
    end
    resp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    resp_rdy = 1'b0;
    vectors++;
    if ({proto_err, out_cnt, resp_val} !== {1'b1, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL proto_sticky: got pe=%b cnt=%0d val=%b, required 1 0 0", proto_err, out_cnt, resp_val);
    end
  endtask

  task automatic test_wrap_reset();
    int g = 0;
    do_reset();
    resp_rdy = 1'b1; req_val = 1'b1;
    while ((returned < 257 || sb.size() > 0) && g < 3000) begin
      req_A = $urandom; req_B = $urandom;
      operands_rdy = (issued < 257);
      result_val   = (model_cnt > 0) && (returned < 257);
      result_bits  = $urandom;
      step();
      g++;
    end
    result_val = 1'b0;
    vectors++;
    if (last_tag !== 8'd0 || returned !== 257 || g >= 3000) begin
      miscompares++;
      $display("FAIL wrap_tag: got last tag=%0d returns=%0d cycles=%0d, required 0 257 <3000", last_tag, returned, g);
    end
    operands_rdy = 1'b1;
    step();
    step();
    operands_rdy = 1'b0; req_val = 1'b0;
    vectors++;
    if ({out_cnt, operands_val, proto_err} !== {3'd2, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_setup: got cnt=%0d ov=%b pe=%b, required 2 1 0", out_cnt, operands_val, proto_err);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({operands_val, resp_val, req_rdy, result_rdy, proto_err, out_cnt, resp_tag,
         resp_bits, operands_bits_A, operands_bits_B} !==
        {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 32'd0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL async_reset: got ov=%b rv=%b qr=%b rr=%b cnt=%0d A=%0d, required 0 0 1 1 0 0",
               operands_val, resp_val, req_rdy, result_rdy, out_cnt, operands_bits_A);
    end
    do_reset();
    req_val = 1'b1; req_A = 32'd21; req_B = 32'd14;
    step();
    drain("post_reset");
    vectors++;
    if (last_tag !== 8'd0 || returned !== 1) begin
      miscompares++;
      $display("FAIL seq_restart: got tag=%0d returns=%0d, required 0 1", last_tag, returned);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time %0t, required earlier finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_outstanding();
    test_backpressure();
    test_same_cycle();
    test_proto_err();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
